// File: rtl/align_shift_pkg.sv
// Shared definitions for the align_shift stage: FSM state encodings.
package align_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/align_shift_fifo.sv
// Input group FIFO: registered storage, head readable the cycle after the
// write (no bypass), exports the number of free slots for flow control.
module align_shift_fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int WIDTH         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [LOG_NUM_SLOTS:0] free_slots
);

  localparam logic [LOG_NUM_SLOTS:0] SLOTS = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);

  logic [WIDTH-1:0]         mem [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LOG_NUM_SLOTS:0]   count;
  logic                     full;
  logic                     do_wr;
  logic                     do_rd;

  assign full       = (count == SLOTS);
  assign empty      = (count == '0);
  assign free_slots = SLOTS - count;
  assign do_wr      = wr_en & ~full;
  assign do_rd      = rd_en & ~empty;
  assign rd_data    = mem[rd_ptr];

  // Storage array; writes into a full FIFO are dropped.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream must never write while the FIFO is full.
  no_write_when_full: assert property (@(posedge clk) disable iff (!rst) !(wr_en && full));

endmodule

// File: rtl/align_shift.sv
// Alignment stage: re-aligns incoming groups by a runtime item offset,
// stitching consecutive groups within an iteration and flushing the tail.
module align_shift
  import align_shift_pkg::*;
#(
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_GROUP_SIZE         = 2,
  parameter int DATA_WIDTH             = 8,
  parameter int FIFO_DEPTH             = 4,
  parameter int LOG_FIFO_DEPTH         = 2,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [LOG_GROUP_SIZE-1:0]         offset,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_in,
  input  logic                              valid_in,
  output logic                              avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_out,
  output logic                              valid_out,
  input  logic                              avail_in,
  output logic                              done
);

  localparam int GW = GROUP_SIZE * DATA_WIDTH;
  localparam logic [LOG_MAX_ITERS-1:0]          ITERS_ONE = 1;
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READS_ONE = 1;
  localparam logic [LOG_FIFO_DEPTH:0]           FREE_MIN  = 2;

  state_t                            state;
  state_t                            state_nxt;
  logic [LOG_MAX_ITERS-1:0]          iters_left;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_left;
  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads;
  logic [LOG_GROUP_SIZE-1:0]         k_reg;
  logic [GW-1:0]                     prev;
  logic                              done_cfg;

  logic [GW-1:0]             fifo_head;
  logic                      fifo_empty;
  logic [LOG_FIFO_DEPTH:0]   free_slots;
  logic                      fifo_rd;
  logic                      out_fire;
  logic                      iter_end;
  logic                      cfg_degenerate;
  logic [GW-1:0]             shifted;

  align_shift_fifo #(
    .NUM_SLOTS    (FIFO_DEPTH),
    .LOG_NUM_SLOTS(LOG_FIFO_DEPTH),
    .WIDTH        (GW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (valid_in),
    .wr_data   (data_in),
    .rd_en     (fifo_rd),
    .rd_data   (fifo_head),
    .empty     (fifo_empty),
    .free_slots(free_slots)
  );

  // Two free slots cover the one-cycle reaction latency of the producer.
  assign avail_out      = (free_slots >= FREE_MIN);
  assign cfg_degenerate = (num_iters == '0) || (num_reads_per_iter == '0);

  // Next-state, FIFO pop and output-fire decisions; configure overrides all.
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    out_fire  = 1'b0;
    iter_end  = 1'b0;
    if (!configure) begin
      case (state)
        ST_PRIME: begin
          if (!fifo_empty) begin
            fifo_rd   = 1'b1;
            state_nxt = (reads_left > READS_ONE) ? ST_RUN : ST_FLUSH;
          end
        end
        ST_RUN: begin
          if (!fifo_empty && avail_in) begin
            fifo_rd  = 1'b1;
            out_fire = 1'b1;
            if (reads_left == READS_ONE) begin
              if (k_reg != '0) begin
                state_nxt = ST_FLUSH;
              end else begin
                iter_end = 1'b1;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (avail_in) begin
            out_fire = 1'b1;
            iter_end = 1'b1;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
      if (iter_end) begin
        if (iters_left == ITERS_ONE) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = (k_reg != '0) ? ST_PRIME : ST_RUN;
        end
      end
    end else begin
      if (cfg_degenerate) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = (offset != '0) ? ST_PRIME : ST_RUN;
      end
    end
  end

  // State, counters and the carried-over previous group.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      iters_left <= '0;
      reads_left <= '0;
      num_reads  <= '0;
      k_reg      <= '0;
      prev       <= '0;
      done_cfg   <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_cfg <= configure && cfg_degenerate;
      if (configure) begin
        iters_left <= num_iters;
        reads_left <= num_reads_per_iter;
        num_reads  <= num_reads_per_iter;
        k_reg      <= offset;
        prev       <= '0;
      end else begin
        if (fifo_rd) begin
          prev       <= fifo_head;
          reads_left <= reads_left - READS_ONE;
        end
        if (iter_end && (iters_left != ITERS_ONE)) begin
          iters_left <= iters_left - ITERS_ONE;
          reads_left <= num_reads;
          prev       <= '0;
        end
      end
    end
  end

  // Window over {cur, prev}; the flush cycle sees an all-zero current group.
  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] prev_g;
  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] cur_g;
  assign prev_g = prev;
  assign cur_g  = (state == ST_FLUSH) ? '0 : fifo_head;

  for (genvar gi = 0; gi < GROUP_SIZE; gi++) begin : g_item
    logic [LOG_GROUP_SIZE:0]   idx;
    logic [LOG_GROUP_SIZE-1:0] sel;
    assign idx = (LOG_GROUP_SIZE+1)'(gi) + {1'b0, k_reg};
    assign sel = idx[LOG_GROUP_SIZE-1:0];
    assign shifted[gi*DATA_WIDTH +: DATA_WIDTH] =
        (k_reg == '0)         ? cur_g[gi]  :
        idx[LOG_GROUP_SIZE]   ? cur_g[sel] : prev_g[sel];
  end

  assign valid_out = out_fire;
  assign data_out  = out_fire ? shifted : '0;
  assign done      = done_cfg | (iter_end && (iters_left == ITERS_ONE));

endmodule

// File: tb/tb_align_shift.sv
// Scoreboard bench for align_shift: expected groups are queued as stimulus
// is driven and compared whenever the DUT emits valid_out or done.
module tb_align_shift;

  logic        clk = 1'b0;
  logic        rst;
  logic        configure;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;
  logic [1:0]  offset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        avail_in;
  logic        done;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;

  align_shift dut (
    .clk               (clk),
    .rst               (rst),
    .configure         (configure),
    .num_iters         (num_iters),
    .num_reads_per_iter(num_reads_per_iter),
    .offset            (offset),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .avail_out         (avail_out),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .avail_in          (avail_in),
    .done              (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic vld, input logic [31:0] d, input logic dn);
    exp_t e;
    e.vld  = vld;
    e.data = d;
    e.dn   = dn;
    exp_q.push_back(e);
  endtask

  task automatic configureRun(input logic [1:0] k, input logic [15:0] r, input logic [15:0] it);
    offset             = k;
    num_reads_per_iter = r;
    num_iters          = it;
    configure          = 1'b1;
    tick();
    configure          = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] d);
    int w = 0;
    while (!avail_out && w < 50) begin
      tick();
      w++;
    end
    if (!avail_out) checkOutput("avail_wait", 32'(avail_out), 32'd1);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    checkOutput({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
  endtask

  // Compare every emitted output or done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en && (valid_out || done)) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out", {30'd0, valid_out, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("valid", 32'(valid_out), 32'(e.vld));
        if (e.vld) checkOutput("data", data_out, e.data);
        checkOutput("done", 32'(done), 32'(e.dn));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    rst                = 1'b0;
    configure          = 1'b0;
    num_iters          = '0;
    num_reads_per_iter = '0;
    offset             = '0;
    data_in            = '0;
    valid_in           = 1'b0;
    avail_in           = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_data", data_out, 32'd0);
    checkOutput("rst_avail", 32'(avail_out), 32'd1);
    mon_en = 1'b1;

    $display("[TB] passthrough k=0");
    configureRun(2'd0, 16'd3, 16'd1);
    pushExp(1'b1, 32'h03020100, 1'b0);
    pushExp(1'b1, 32'h07060504, 1'b0);
    pushExp(1'b1, 32'h0B0A0908, 1'b1);
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    applyStimulus(32'h0B0A0908);
    waitDrain("pass");

    $display("[TB] shift k=1");
    configureRun(2'd1, 16'd2, 16'd1);
    pushExp(1'b1, 32'h04030201, 1'b0);
    pushExp(1'b1, 32'h00070605, 1'b1);
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    waitDrain("shift");

    $display("[TB] multi-iteration k=3");
    configureRun(2'd3, 16'd1, 16'd2);
    pushExp(1'b1, 32'h00000003, 1'b0);
    pushExp(1'b1, 32'h00000007, 1'b1);
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    waitDrain("multi");

    $display("[TB] backpressure");
    avail_in = 1'b0;
    configureRun(2'd1, 16'd2, 16'd1);
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    applyStimulus(32'h0B0A0908);
    applyStimulus(32'h0F0E0D0C);
    checkOutput("bp_avail_full", 32'(avail_out), 32'd0);
    repeat (5) tick();
    checkOutput("bp_valid_held", 32'(valid_out), 32'd0);
    checkOutput("bp_avail_held", 32'(avail_out), 32'd0);
    pushExp(1'b1, 32'h04030201, 1'b0);
    pushExp(1'b1, 32'h00070605, 1'b1);
    avail_in = 1'b1;
    waitDrain("bp");
    configureRun(2'd1, 16'd2, 16'd1);
    pushExp(1'b1, 32'h0C0B0A09, 1'b0);
    pushExp(1'b1, 32'h000F0E0D, 1'b1);
    waitDrain("bp_leftover");

    $display("[TB] degenerate configurations");
    pushExp(1'b0, 32'h0, 1'b1);
    configureRun(2'd1, 16'd2, 16'd0);
    checkOutput("degen_iters_done", 32'(done), 32'd1);
    checkOutput("degen_iters_valid", 32'(valid_out), 32'd0);
    waitDrain("degen_iters");
    pushExp(1'b0, 32'h0, 1'b1);
    configureRun(2'd2, 16'd0, 16'd3);
    checkOutput("degen_reads_done", 32'(done), 32'd1);
    checkOutput("degen_reads_valid", 32'(valid_out), 32'd0);
    waitDrain("degen_reads");

    $display("[TB] reset mid-run");
    configureRun(2'd1, 16'd2, 16'd1);
    pushExp(1'b1, 32'h04030201, 1'b0);
    pushExp(1'b1, 32'h00070605, 1'b1);
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    w = 0;
    while (!(valid_out && exp_q.size() == 2) && w < 50) begin
      tick();
      w++;
    end
    checkOutput("rst_first_seen", 32'(valid_out), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("rst_first_out", 32'(exp_q.size()), 32'd1);
    rst      = 1'b0;
    avail_in = 1'b0;
    exp_q.delete();
    tick();
    tick();
    checkOutput("midrst_valid", 32'(valid_out), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    rst      = 1'b1;
    avail_in = 1'b1;
    tick();
    checkOutput("midrst_avail", 32'(avail_out), 32'd1);
    checkOutput("midrst_valid_after", 32'(valid_out), 32'd0);
    repeat (5) tick();
    configureRun(2'd1, 16'd2, 16'd1);
    pushExp(1'b1, 32'h04030201, 1'b0);
    pushExp(1'b1, 32'h00070605, 1'b1);
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    waitDrain("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
